// File: rtl/axil_arb_pkg.sv
// Shared types for the two-port AXI4-lite arbiter.
// Port 0 is the UART loader, port 1 the host.
package axil_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } arb_state_t;

  localparam logic PORT_UART = 1'b0;
  localparam logic PORT_HOST = 1'b1;

endpackage

// File: rtl/axil_arb2_rr.sv
// Two-requester round-robin pick; last is the index
// of the port that owned the bus most recently.
module rr_arb2
  import axil_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (req == 2'b11):
        gnt = (last == PORT_HOST) ? 2'b01 : 2'b10;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axil_arb2.sv
// Two-slave to one-master AXI4-lite arbiter, one
// transaction in flight, round-robin on ties.
module axil_arb2
  import axil_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
  input  logic [2:0]            s0_axil_awprot,
  input  logic                  s0_axil_awvalid,
  output logic                  s0_axil_awready,
  input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
  input  logic                  s0_axil_wvalid,
  output logic                  s0_axil_wready,
  output logic [1:0]            s0_axil_bresp,
  output logic                  s0_axil_bvalid,
  input  logic                  s0_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,

  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic [1:0]            s1_axil_bresp,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,

  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready,

  output logic [1:0]            grant
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;
  logic       aw_done_q, aw_done_d;
  logic       w_done_q, w_done_d;
  logic [1:0] rr_gnt;
  logic       sel;
  logic       aw_hs, w_hs;

  logic [1:0] awv, wv, arv, bry, rry;
  logic [1:0] awry, wry, arry, bval, rval;
  logic [1:0][1:0]            bresp_v, rresp_v;
  logic [1:0][DATA_WIDTH-1:0] rdata_v;

  logic [ADDR_WIDTH-1:0] awaddr_s, araddr_s;
  logic [2:0]            awprot_s, arprot_s;
  logic [DATA_WIDTH-1:0] wdata_s;
  logic [STRB_WIDTH-1:0] wstrb_s;

  assign awv = {s1_axil_awvalid, s0_axil_awvalid};
  assign wv  = {s1_axil_wvalid,  s0_axil_wvalid};
  assign arv = {s1_axil_arvalid, s0_axil_arvalid};
  assign bry = {s1_axil_bready,  s0_axil_bready};
  assign rry = {s1_axil_rready,  s0_axil_rready};

  assign sel   = grant_q[PORT_HOST];
  assign grant = grant_q;

  assign awaddr_s = sel ? s1_axil_awaddr : s0_axil_awaddr;
  assign awprot_s = sel ? s1_axil_awprot : s0_axil_awprot;
  assign wdata_s  = sel ? s1_axil_wdata  : s0_axil_wdata;
  assign wstrb_s  = sel ? s1_axil_wstrb  : s0_axil_wstrb;
  assign araddr_s = sel ? s1_axil_araddr : s0_axil_araddr;
  assign arprot_s = sel ? s1_axil_arprot : s0_axil_arprot;

  rr_arb2 u_rr (
    .req  (awv | arv),
    .last (last_q),
    .gnt  (rr_gnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= PORT_HOST;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    aw_hs     = 1'b0;
    w_hs      = 1'b0;

    m_axil_awaddr  = '0;
    m_axil_awprot  = '0;
    m_axil_awvalid = 1'b0;
    m_axil_wdata   = '0;
    m_axil_wstrb   = '0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    m_axil_araddr  = '0;
    m_axil_arprot  = '0;
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;

    awry    = 2'b00;
    wry     = 2'b00;
    arry    = 2'b00;
    bval    = 2'b00;
    rval    = 2'b00;
    bresp_v = '0;
    rresp_v = '0;
    rdata_v = '0;

    unique case (state_q)
      IDLE: begin
        if (rr_gnt != 2'b00) begin
          grant_d = rr_gnt;
          // write wins over read inside the granted port
          state_d = ((awv & rr_gnt) != 2'b00) ? WR : RD_ADDR;
        end
      end
      WR: begin
        m_axil_awaddr  = awaddr_s;
        m_axil_awprot  = awprot_s;
        m_axil_awvalid = awv[sel] && !aw_done_q;
        m_axil_wdata   = wdata_s;
        m_axil_wstrb   = wstrb_s;
        m_axil_wvalid  = wv[sel] && !w_done_q;
        awry[sel] = m_axil_awready && !aw_done_q;
        wry[sel]  = m_axil_wready && !w_done_q;
        aw_hs = awv[sel] && !aw_done_q && m_axil_awready;
        w_hs  = wv[sel] && !w_done_q && m_axil_wready;
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
          state_d   = WR_RESP;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      WR_RESP: begin
        m_axil_bready = bry[sel];
        bval[sel]     = m_axil_bvalid;
        bresp_v[sel]  = m_axil_bresp;
        if (m_axil_bvalid && bry[sel]) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = sel;
        end
      end
      RD_ADDR: begin
        m_axil_araddr  = araddr_s;
        m_axil_arprot  = arprot_s;
        m_axil_arvalid = arv[sel];
        arry[sel]      = m_axil_arready;
        if (arv[sel] && m_axil_arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        m_axil_rready = rry[sel];
        rval[sel]     = m_axil_rvalid;
        rresp_v[sel]  = m_axil_rresp;
        rdata_v[sel]  = m_axil_rdata;
        if (m_axil_rvalid && rry[sel]) begin
          state_d = IDLE;
          grant_d = 2'b00;
          last_d  = sel;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
    endcase
  end

  assign s0_axil_awready = awry[0];
  assign s0_axil_wready  = wry[0];
  assign s0_axil_bvalid  = bval[0];
  assign s0_axil_bresp   = bresp_v[0];
  assign s0_axil_arready = arry[0];
  assign s0_axil_rvalid  = rval[0];
  assign s0_axil_rresp   = rresp_v[0];
  assign s0_axil_rdata   = rdata_v[0];

  assign s1_axil_awready = awry[1];
  assign s1_axil_wready  = wry[1];
  assign s1_axil_bvalid  = bval[1];
  assign s1_axil_bresp   = bresp_v[1];
  assign s1_axil_arready = arry[1];
  assign s1_axil_rvalid  = rval[1];
  assign s1_axil_rresp   = rresp_v[1];
  assign s1_axil_rdata   = rdata_v[1];

endmodule

// File: tb/tb_axil_arb2.sv
// Directed bench for axil_arb2 with a 4-word
// AXI4-lite RAM model on the master port.
module tb_axil_arb2;
  import axil_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0] awvalid, awready, wvalid, wready;
  logic [1:0] bvalid, bready, arvalid, arready;
  logic [1:0] rvalid, rready;
  logic [3:0]  awaddr [2];
  logic [3:0]  araddr [2];
  logic [2:0]  awprot [2];
  logic [2:0]  arprot [2];
  logic [31:0] wdata  [2];
  logic [31:0] rdata  [2];
  logic [3:0]  wstrb  [2];
  logic [1:0]  bresp  [2];
  logic [1:0]  rresp  [2];

  logic [3:0]  m_awaddr, m_araddr;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_awready, m_wvalid, m_wready;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_bvalid, m_bready, m_arvalid, m_arready;
  logic        m_rvalid, m_rready;
  logic [1:0]  m_bresp, m_rresp;
  logic [1:0]  grant;

  axil_arb2 dut (
    .clk(clk), .rst(rst),
    .s0_axil_awaddr(awaddr[0]), .s0_axil_awprot(awprot[0]),
    .s0_axil_awvalid(awvalid[0]), .s0_axil_awready(awready[0]),
    .s0_axil_wdata(wdata[0]), .s0_axil_wstrb(wstrb[0]),
    .s0_axil_wvalid(wvalid[0]), .s0_axil_wready(wready[0]),
    .s0_axil_bresp(bresp[0]), .s0_axil_bvalid(bvalid[0]),
    .s0_axil_bready(bready[0]),
    .s0_axil_araddr(araddr[0]), .s0_axil_arprot(arprot[0]),
    .s0_axil_arvalid(arvalid[0]), .s0_axil_arready(arready[0]),
    .s0_axil_rdata(rdata[0]), .s0_axil_rresp(rresp[0]),
    .s0_axil_rvalid(rvalid[0]), .s0_axil_rready(rready[0]),
    .s1_axil_awaddr(awaddr[1]), .s1_axil_awprot(awprot[1]),
    .s1_axil_awvalid(awvalid[1]), .s1_axil_awready(awready[1]),
    .s1_axil_wdata(wdata[1]), .s1_axil_wstrb(wstrb[1]),
    .s1_axil_wvalid(wvalid[1]), .s1_axil_wready(wready[1]),
    .s1_axil_bresp(bresp[1]), .s1_axil_bvalid(bvalid[1]),
    .s1_axil_bready(bready[1]),
    .s1_axil_araddr(araddr[1]), .s1_axil_arprot(arprot[1]),
    .s1_axil_arvalid(arvalid[1]), .s1_axil_arready(arready[1]),
    .s1_axil_rdata(rdata[1]), .s1_axil_rresp(rresp[1]),
    .s1_axil_rvalid(rvalid[1]), .s1_axil_rready(rready[1]),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot),
    .m_axil_awvalid(m_awvalid), .m_axil_awready(m_awready),
    .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
    .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready),
    .m_axil_bresp(m_bresp), .m_axil_bvalid(m_bvalid),
    .m_axil_bready(m_bready),
    .m_axil_araddr(m_araddr), .m_axil_arprot(m_arprot),
    .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp),
    .m_axil_rvalid(m_rvalid), .m_axil_rready(m_rready),
    .grant(grant)
  );

  // RAM model: one-cycle write commit, one-cycle read latency
  logic [31:0] mem [4];
  logic        ram_aw_got, ram_w_got;
  logic [3:0]  ram_awa;
  logic [31:0] ram_wd;
  logic [3:0]  ram_ws;

  assign m_awready = !ram_aw_got;
  assign m_wready  = !ram_w_got;
  assign m_arready = !m_rvalid;
  assign m_bresp   = 2'b00;
  assign m_rresp   = 2'b00;

  always @(posedge clk) begin
    if (rst) begin
      ram_aw_got <= 1'b0;
      ram_w_got  <= 1'b0;
      m_bvalid   <= 1'b0;
      m_rvalid   <= 1'b0;
      m_rdata    <= '0;
      mem[0] <= 32'h1111_1111;
      mem[1] <= 32'h2222_2222;
      mem[2] <= 32'h3333_3333;
      mem[3] <= 32'h4444_4444;
    end else begin
      if (m_awvalid && m_awready) begin
        ram_aw_got <= 1'b1;
        ram_awa    <= m_awaddr;
      end
      if (m_wvalid && m_wready) begin
        ram_w_got <= 1'b1;
        ram_wd    <= m_wdata;
        ram_ws    <= m_wstrb;
      end
      if (ram_aw_got && ram_w_got && !m_bvalid) begin
        for (int b = 0; b < 4; b++)
          if (ram_ws[b])
            mem[ram_awa[3:2]][8*b +: 8] <= ram_wd[8*b +: 8];
        m_bvalid   <= 1'b1;
        ram_aw_got <= 1'b0;
        ram_w_got  <= 1'b0;
      end
      if (m_bvalid && m_bready) m_bvalid <= 1'b0;
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem[m_araddr[3:2]];
      end
      if (m_rvalid && m_rready) m_rvalid <= 1'b0;
    end
  end

  // Monitors: grant log, leaks, b counts, WR_RESP ordering
  logic [1:0] glog [$];
  logic [1:0] prev_grant;
  int leak, bcnt0, bcnt1, order_err;
  logic seen_aw;

  always @(posedge clk) begin
    if (rst) begin
      prev_grant <= 2'b00;
      leak <= 0; bcnt0 <= 0; bcnt1 <= 0;
      order_err <= 0; seen_aw <= 1'b0;
    end else begin
      if (grant != 2'b00 && prev_grant == 2'b00)
        glog.push_back(grant);
      prev_grant <= grant;
      if ((rvalid[0] || bvalid[0]) && grant != 2'b01)
        leak <= leak + 1;
      if ((rvalid[1] || bvalid[1]) && grant != 2'b10)
        leak <= leak + 1;
      if (bvalid[0] && bready[0]) bcnt0 <= bcnt0 + 1;
      if (bvalid[1] && bready[1]) bcnt1 <= bcnt1 + 1;
      if (dut.state_q == WR && m_awvalid && m_awready)
        seen_aw <= 1'b1;
      if (dut.state_q == IDLE) seen_aw <= 1'b0;
      if (dut.state_q == WR_RESP && !seen_aw)
        order_err <= order_err + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic do_reset();
    rst = 1'b1;
    awvalid = '0; wvalid = '0; arvalid = '0;
    bready = '0; rready = '0;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; awprot[i] = '0; araddr[i] = '0;
      arprot[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    glog.delete();
  endtask

  task automatic do_write(input int p, input logic [3:0] a,
                          input logic [31:0] d,
                          input logic [3:0] s, input int lead,
                          output logic [1:0] r);
    int n;
    bit aw_ok, w_ok, ah, wh, got;
    awaddr[p] = a; awprot[p] = 3'b000;
    wdata[p] = d; wstrb[p] = s;
    wvalid[p] = 1'b1;
    repeat (lead) begin
      #1;
      tests++;
      if (wready[p] !== 1'b0 || grant !== 2'b00 ||
          dut.state_q !== IDLE) begin
        fails++;
        $display("FAIL w_lead_stall p=%0d wready=%b grant=%b state=%0d, required 0 00 IDLE",
                 p, wready[p], grant, dut.state_q);
      end
      @(negedge clk);
    end
    awvalid[p] = 1'b1;
    aw_ok = 0; w_ok = 0; got = 0; n = 0;
    r = 2'b11;
    while (!(aw_ok && w_ok) && n < 50) begin
      #1;
      ah = awvalid[p] && awready[p];
      wh = wvalid[p] && wready[p];
      @(negedge clk);
      if (ah) begin awvalid[p] = 1'b0; aw_ok = 1; end
      if (wh) begin wvalid[p] = 1'b0; w_ok = 1; end
      n++;
    end
    bready[p] = 1'b1;
    while (!got && n < 100) begin
      #1;
      if (bvalid[p]) begin got = 1; r = bresp[p]; end
      @(negedge clk);
      n++;
    end
    bready[p] = 1'b0;
    awvalid[p] = 1'b0; wvalid[p] = 1'b0;
    tests++;
    if (!(aw_ok && w_ok && got)) begin
      fails++;
      $display("FAIL write_done p=%0d aw=%0d w=%0d b=%0d, required 1 1 1",
               p, aw_ok, w_ok, got);
    end
  endtask

  task automatic do_read(input int p, input logic [3:0] a,
                         output logic [31:0] d);
    int n;
    bit ar_ok, got, ah;
    araddr[p] = a; arprot[p] = 3'b000;
    arvalid[p] = 1'b1; rready[p] = 1'b1;
    ar_ok = 0; got = 0; n = 0;
    d = 32'hx;
    while (!ar_ok && n < 50) begin
      #1;
      ah = arready[p];
      @(negedge clk);
      if (ah) begin arvalid[p] = 1'b0; ar_ok = 1; end
      n++;
    end
    while (!got && n < 100) begin
      #1;
      if (rvalid[p]) begin got = 1; d = rdata[p]; end
      @(negedge clk);
      n++;
    end
    rready[p] = 1'b0; arvalid[p] = 1'b0;
    tests++;
    if (!(ar_ok && got)) begin
      fails++;
      $display("FAIL read_done p=%0d ar=%0d r=%0d, required 1 1",
               p, ar_ok, got);
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    tests++;
    if (grant !== 2'b00 || dut.state_q !== IDLE) begin
      fails++;
      $display("FAIL reset_state grant=%b state=%0d, required 00 IDLE",
               grant, dut.state_q);
    end
    tests++;
    if ({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
         awready, wready, arready, bvalid, rvalid} !== '0) begin
      fails++;
      $display("FAIL reset_outputs mv=%b%b%b%b%b sr=%b%b%b sv=%b%b, required all 0",
               m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready,
               awready, wready, arready, bvalid, rvalid);
    end
    @(negedge clk);
  endtask

  task automatic test_s0_write();
    logic [1:0] r;
    do_reset();
    fork
      do_write(0, 4'h4, 32'hDEAD_BEEF, 4'hF, 0, r);
      begin
        #1;
        tests++;
        if (grant !== 2'b00) begin
          fails++;
          $display("FAIL grant_bubble got=%b, required 00", grant);
        end
        @(negedge clk);
        #1;
        tests++;
        if (grant !== 2'b01) begin
          fails++;
          $display("FAIL grant_s0 got=%b, required 01", grant);
        end
      end
    join
    #1;
    tests++;
    if (mem[1] !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL s0_write_mem got=%h, required deadbeef", mem[1]);
    end
    tests++;
    if (r !== 2'b00 || bcnt0 !== 1) begin
      fails++;
      $display("FAIL s0_bresp resp=%b cnt=%0d, required 00 1", r, bcnt0);
    end
    tests++;
    if (grant !== 2'b00) begin
      fails++;
      $display("FAIL grant_clear got=%b, required 00", grant);
    end
    @(negedge clk);
  endtask

  task automatic test_read_tie();
    logic [31:0] d0, d1;
    do_reset();
    fork
      do_read(0, 4'h0, d0);
      do_read(1, 4'h8, d1);
    join
    tests++;
    if (d0 !== 32'h1111_1111 || d1 !== 32'h3333_3333) begin
      fails++;
      $display("FAIL tie_rdata s0=%h s1=%h, required 11111111 33333333",
               d0, d1);
    end
    tests++;
    if (glog.size() != 2 || glog[0] !== 2'b01 || glog[1] !== 2'b10) begin
      fails++;
      $display("FAIL tie_order n=%0d first=%b, required 2 01 then 10",
               glog.size(), (glog.size() > 0) ? glog[0] : 2'bxx);
    end
    tests++;
    if (leak !== 0) begin
      fails++;
      $display("FAIL tie_leak got=%0d, required 0", leak);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r;
    do_reset();
    do_write(1, 4'hC, 32'hCAFE_F00D, 4'hF, 3, r);
    #1;
    tests++;
    if (r !== 2'b00 || bcnt1 !== 1 || bcnt0 !== 0) begin
      fails++;
      $display("FAIL wlead_bresp resp=%b b1=%0d b0=%0d, required 00 1 0",
               r, bcnt1, bcnt0);
    end
    tests++;
    if (mem[3] !== 32'hCAFE_F00D || order_err !== 0) begin
      fails++;
      $display("FAIL wlead_mem mem=%h order=%0d, required cafef00d 0",
               mem[3], order_err);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w;
    logic [1:0]  exp_g;
    do_reset();
    fork
      begin
        logic [1:0] r0;
        for (int k = 0; k < 4; k++)
          do_write(0, 4'(k * 4), 32'hFFFF_A000 | 32'(k),
                   4'b0011, 0, r0);
      end
      begin
        logic [1:0] r1;
        for (int k = 0; k < 4; k++)
          do_write(1, 4'(k * 4), {16'hB000 | 16'(k), 16'hEEEE},
                   4'b1100, 0, r1);
      end
    join
    #1;
    tests++;
    if (glog.size() != 8) begin
      fails++;
      $display("FAIL b2b_grants n=%0d, required 8", glog.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
        tests++;
        if (glog[i] !== exp_g) begin
          fails++;
          $display("FAIL b2b_alt i=%0d got=%b, required %b",
                   i, glog[i], exp_g);
        end
      end
    end
    tests++;
    if (bcnt0 !== 4 || bcnt1 !== 4 || leak !== 0 ||
        order_err !== 0) begin
      fails++;
      $display("FAIL b2b_bresp b0=%0d b1=%0d leak=%0d ord=%0d, required 4 4 0 0",
               bcnt0, bcnt1, leak, order_err);
    end
    for (int k = 0; k < 4; k++) begin
      exp_w = {16'hB000 | 16'(k), 16'hA000 | 16'(k)};
      tests++;
      if (mem[k] !== exp_w) begin
        fails++;
        $display("FAIL b2b_mem k=%0d got=%h, required %h",
                 k, mem[k], exp_w);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_write_then_read();
    logic [1:0]  r;
    logic [31:0] d;
    do_reset();
    fork
      do_write(0, 4'h8, 32'h0BAD_C0DE, 4'hF, 0, r);
      do_read(0, 4'h8, d);
    join
    tests++;
    if (d !== 32'h0BAD_C0DE || r !== 2'b00) begin
      fails++;
      $display("FAIL wr_before_rd rdata=%h resp=%b, required 0badc0de 00",
               d, r);
    end
    tests++;
    if (glog.size() != 2) begin
      fails++;
      $display("FAIL wr_rd_grants n=%0d, required 2", glog.size());
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d;
    int n;
    do_reset();
    araddr[0] = 4'h4; arprot[0] = 3'b000;
    arvalid[0] = 1'b1; rready[0] = 1'b0;
    n = 0;
    while (dut.state_q != RD_DATA && n < 20) begin
      @(negedge clk);
      if (dut.state_q == RD_DATA) arvalid[0] = 1'b0;
      n++;
    end
    arvalid[0] = 1'b0;
    @(negedge clk);
    tests++;
    if (dut.state_q !== RD_DATA) begin
      fails++;
      $display("FAIL rd_stall state=%0d, required RD_DATA", dut.state_q);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++;
    if (grant !== 2'b00 || dut.state_q !== IDLE) begin
      fails++;
      $display("FAIL midrst_state grant=%b state=%0d, required 00 IDLE",
               grant, dut.state_q);
    end
    tests++;
    if ({m_awvalid, m_wvalid, m_arvalid, rvalid, bvalid} !== '0) begin
      fails++;
      $display("FAIL midrst_valids aw=%b w=%b ar=%b r=%b b=%b, required 0",
               m_awvalid, m_wvalid, m_arvalid, rvalid, bvalid);
    end
    @(negedge clk);
    do_read(1, 4'hC, d);
    tests++;
    if (d !== 32'h4444_4444) begin
      fails++;
      $display("FAIL midrst_s1_read got=%h, required 44444444", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_s0_write();
    test_read_tie();
    test_w_before_aw();
    test_back_to_back();
    test_write_then_read();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
